// File: rtl/gene_pair_aligner.sv
// gene_pair_aligner
//   Merges two key-sorted parent gene streams into one stream of aligned gene
//   pairs for the mating PE. A job emits the PE setup word first. It then emits
//   one (data1, data2) pair per inherited gene, following NEAT alignment:
//     - Matching keys are emitted as (g1, g2).
//     - Disjoint or excess genes are kept only when they come from the fitter
//       parent. They are emitted as (g, g).
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   start                 one-cycle job start (ignored while busy)
//   cfg_word              setup word: [63:56] p1 fitness, [55:48] p2 fitness,
//                         [47:0] mutation probabilities (sampled on start)
//   child_id              child genome id (sampled on start)
//   pX_valid/gene/last    parent X head gene, valid flag, final-gene flag
//   pX_ready              parent X head gene consumed this cycle
//   out_valid/out_setup   registered output beat valid / beat is setup word
//   out_data1/out_data2   registered output pair (zero when out_valid=0)
//   busy                  job in progress (state != IDLE)
//   done                  one-cycle job-complete pulse
//   gene_count            gene pairs emitted in the current/last job
module gene_pair_aligner #(
  parameter int GENE_SZ = 64,
  parameter int KEY_HI  = 55,
  parameter int KEY_LO  = 32,
  parameter int CNT_SZ  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [GENE_SZ-1:0] cfg_word,
  input  logic [7:0]         child_id,
  input  logic               p1_valid,
  input  logic [GENE_SZ-1:0] p1_gene,
  input  logic               p1_last,
  output logic               p1_ready,
  input  logic               p2_valid,
  input  logic [GENE_SZ-1:0] p2_gene,
  input  logic               p2_last,
  output logic               p2_ready,
  output logic               out_valid,
  output logic               out_setup,
  output logic [GENE_SZ-1:0] out_data1,
  output logic [GENE_SZ-1:0] out_data2,
  output logic               busy,
  output logic               done,
  output logic [CNT_SZ-1:0]  gene_count
);

  typedef enum logic [1:0] {IDLE, SETUP, MERGE, DONE} state_t;

  state_t               state_reg, state_next;
  logic [GENE_SZ-1:0]   cfg_reg, cfg_next;
  logic [7:0]           child_id_reg, child_id_next;
  logic                 fitter_reg, fitter_next;   // 0 = parent1, 1 = parent2
  logic                 p1_end_reg, p1_end_next;
  logic                 p2_end_reg, p2_end_next;
  logic [CNT_SZ-1:0]    gene_count_reg, gene_count_next;

  logic                 out_valid_reg, out_setup_reg;
  logic [GENE_SZ-1:0]   out_data1_reg, out_data2_reg;

  // Next output beat, registered one cycle later.
  logic                 beat_valid, beat_setup;
  logic [GENE_SZ-1:0]   beat_d1, beat_d2;

  logic                 pop1, pop2;
  logic [KEY_HI-KEY_LO:0] k1, k2;

  assign k1 = p1_gene[KEY_HI:KEY_LO];
  assign k2 = p2_gene[KEY_HI:KEY_LO];

  always_comb begin
    state_next      = state_reg;
    cfg_next        = cfg_reg;
    child_id_next   = child_id_reg;
    fitter_next     = fitter_reg;
    p1_end_next     = p1_end_reg;
    p2_end_next     = p2_end_reg;
    gene_count_next = gene_count_reg;
    pop1            = 1'b0;
    pop2            = 1'b0;
    beat_valid      = 1'b0;
    beat_setup      = 1'b0;
    beat_d1         = '0;
    beat_d2         = '0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          cfg_next        = cfg_word;
          child_id_next   = child_id;
          // Ties favour parent1.
          fitter_next     = (cfg_word[GENE_SZ-9 -: 8] > cfg_word[GENE_SZ-1 -: 8]);
          p1_end_next     = 1'b0;
          p2_end_next     = 1'b0;
          gene_count_next = '0;
          state_next      = SETUP;
        end
      end

      SETUP: begin
        beat_valid = 1'b1;
        beat_setup = 1'b1;
        beat_d1    = cfg_reg;
        beat_d2    = {{(GENE_SZ-8){1'b0}}, child_id_reg};
        state_next = MERGE;
      end

      MERGE: begin
        // While both parents are live, decide only when both heads are
        // present. Equal keys pop both; otherwise pop the smaller key.
        if (!p1_end_reg && !p2_end_reg) begin
          if (p1_valid && p2_valid) begin
            pop1 = (k1 <= k2);
            pop2 = (k2 <= k1);
          end
        end else if (!p1_end_reg) begin
          pop1 = p1_valid;
        end else if (!p2_end_reg) begin
          pop2 = p2_valid;
        end

        if (pop1 && pop2) begin
          beat_valid = 1'b1;
          beat_d1    = p1_gene;
          beat_d2    = p2_gene;
        end else if (pop1 && !fitter_reg) begin
          beat_valid = 1'b1;
          beat_d1    = p1_gene;
          beat_d2    = p1_gene;
        end else if (pop2 && fitter_reg) begin
          beat_valid = 1'b1;
          beat_d1    = p2_gene;
          beat_d2    = p2_gene;
        end

        if (beat_valid && !(&gene_count_reg))
          gene_count_next = gene_count_reg + 1'b1;

        p1_end_next = p1_end_reg | (pop1 & p1_last);
        p2_end_next = p2_end_reg | (pop2 & p2_last);
        if (p1_end_next && p2_end_next)
          state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cfg_reg        <= '0;
      child_id_reg   <= '0;
      fitter_reg     <= 1'b0;
      p1_end_reg     <= 1'b0;
      p2_end_reg     <= 1'b0;
      gene_count_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_setup_reg  <= 1'b0;
      out_data1_reg  <= '0;
      out_data2_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      cfg_reg        <= cfg_next;
      child_id_reg   <= child_id_next;
      fitter_reg     <= fitter_next;
      p1_end_reg     <= p1_end_next;
      p2_end_reg     <= p2_end_next;
      gene_count_reg <= gene_count_next;
      out_valid_reg  <= beat_valid;
      out_setup_reg  <= beat_setup;
      out_data1_reg  <= beat_d1;
      out_data2_reg  <= beat_d2;
    end
  end

  assign p1_ready   = pop1;
  assign p2_ready   = pop2;
  assign out_valid  = out_valid_reg;
  assign out_setup  = out_setup_reg;
  assign out_data1  = out_data1_reg;
  assign out_data2  = out_data2_reg;
  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign gene_count = gene_count_reg;

endmodule
